// File: rtl/mem_stage_if.sv
// Bundle of the Execute-side, data-memory and Writeback-side signals of the
// memory-access stage. The stage itself connects through the slave modport;
// whatever surrounds it (Execute, data memory, Writeback) uses master.
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Execute -> stage
    logic                  MEM_valid_in;
    logic [31:0]           MEM_alures_in;
    logic [31:0]           MEM_store_data_in;
    logic [1:0]            MEM_op_in;
    logic [2:0]            MEM_op2_in;
    logic [5:0]            MEM_op3_in;
    logic [4:0]            MEM_rd_in;
    logic                  mem_ready;

    // stage <-> data memory
    logic                  dmem_req_out;
    logic                  dmem_we_out;
    logic [ADDR_WIDTH-1:0] dmem_addr_out;
    logic [3:0]            dmem_be_out;
    logic [DATA_WIDTH-1:0] dmem_wdata_out;
    logic                  dmem_ack_in;
    logic [DATA_WIDTH-1:0] dmem_rdata_in;

    // stage -> Writeback
    logic                  MEM_wb_en_out;
    logic [4:0]            MEM_wb_rd_out;
    logic [DATA_WIDTH-1:0] MEM_wb_data_out;
    logic                  MEM_trap_out;

    modport master (
        output MEM_valid_in, MEM_alures_in, MEM_store_data_in,
               MEM_op_in, MEM_op2_in, MEM_op3_in, MEM_rd_in,
               dmem_ack_in, dmem_rdata_in,
        input  mem_ready, dmem_req_out, dmem_we_out, dmem_addr_out,
               dmem_be_out, dmem_wdata_out,
               MEM_wb_en_out, MEM_wb_rd_out, MEM_wb_data_out, MEM_trap_out
    );

    modport slave (
        input  MEM_valid_in, MEM_alures_in, MEM_store_data_in,
               MEM_op_in, MEM_op2_in, MEM_op3_in, MEM_rd_in,
               dmem_ack_in, dmem_rdata_in,
        output mem_ready, dmem_req_out, dmem_we_out, dmem_addr_out,
               dmem_be_out, dmem_wdata_out,
               MEM_wb_en_out, MEM_wb_rd_out, MEM_wb_data_out, MEM_trap_out
    );
endinterface

// File: rtl/mem_stage.sv
// SPARC V8 memory-access stage. Non-memory results pass through with one
// cycle of latency; loads and stores run one request at a time over the
// data-memory handshake, with big-endian lane selection and extension.
module mem_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_e;
    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    typedef struct packed {
        size_e size;       // SZ_NONE: not a load/store
        logic  is_store;
        logic  is_signed;  // LDSB/LDSH
    } memop_t;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_CALL   = 2'b01;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;
    localparam logic [2:0] OP2_SETHI = 3'b100;
    localparam logic [4:0] RD_LINK   = 5'd15;  // CALL writes %o7

    localparam memop_t MEMOP_NONE = '{size: SZ_NONE, is_store: 1'b0, is_signed: 1'b0};

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wb_en_q, wb_en_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  trap_q, trap_d;

    // Context of the access in flight, needed to shape the load result.
    memop_t                pend_q, pend_d;
    logic [1:0]            off_q, off_d;
    logic [4:0]            rd_q, rd_d;

    memop_t                dec;
    logic [1:0]            off;
    logic                  aligned;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;

    // Select and extend the addressed lane of a read word (byte 0 = MSB).
    function automatic logic [DATA_WIDTH-1:0] load_lane(
        input memop_t                op,
        input logic [1:0]            o,
        input logic [DATA_WIDTH-1:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (o)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = o[1] ? rdata[15:0] : rdata[31:16];
        case (op.size)
            SZ_BYTE: return op.is_signed ? {{24{b[7]}}, b} : {24'b0, b};
            SZ_HALF: return op.is_signed ? {{16{h[15]}}, h} : {16'b0, h};
            default: return rdata;
        endcase
    endfunction

    // Decode the incoming instruction: access size, direction, alignment and lane shaping.
    // NOTE: every signal gets a default before the case, so no path can leave it unassigned and infer a latch.
    always_comb begin
        dec      = MEMOP_NONE;
        off      = bus.MEM_alures_in[1:0];
        aligned  = 1'b1;
        st_be    = 4'b1111;
        st_wdata = bus.MEM_store_data_in;
        if (bus.MEM_op_in == OP_MEM) begin
            case (bus.MEM_op3_in)
                6'b000000: dec = '{size: SZ_WORD, is_store: 1'b0, is_signed: 1'b0};  // LD
                6'b000001: dec = '{size: SZ_BYTE, is_store: 1'b0, is_signed: 1'b0};  // LDUB
                6'b000010: dec = '{size: SZ_HALF, is_store: 1'b0, is_signed: 1'b0};  // LDUH
                6'b001001: dec = '{size: SZ_BYTE, is_store: 1'b0, is_signed: 1'b1};  // LDSB
                6'b001010: dec = '{size: SZ_HALF, is_store: 1'b0, is_signed: 1'b1};  // LDSH
                6'b000100: dec = '{size: SZ_WORD, is_store: 1'b1, is_signed: 1'b0};  // ST
                6'b000101: dec = '{size: SZ_BYTE, is_store: 1'b1, is_signed: 1'b0};  // STB
                6'b000110: dec = '{size: SZ_HALF, is_store: 1'b1, is_signed: 1'b0};  // STH
                default:   dec = MEMOP_NONE;
            endcase
        end
        case (dec.size)
            SZ_BYTE: begin
                st_be    = 4'b1000 >> off;
                st_wdata = {4{bus.MEM_store_data_in[7:0]}};
            end
            SZ_HALF: begin
                aligned  = ~off[0];
                st_be    = off[1] ? 4'b0011 : 4'b1100;
                st_wdata = {2{bus.MEM_store_data_in[15:0]}};
            end
            SZ_WORD: aligned = (off == 2'b00);
            default: ;
        endcase
    end

    // Next state and next registered outputs: accept in IDLE, hold the request in WAIT.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        trap_d    = 1'b0;
        pend_d    = pend_q;
        off_d     = off_q;
        rd_d      = rd_q;

        case (state_q)
            S_IDLE: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                addr_d  = '0;
                be_d    = '0;
                wdata_d = '0;
                if (bus.MEM_valid_in) begin
                    if (dec.size != SZ_NONE) begin
                        if (aligned) begin
                            state_d = S_WAIT;
                            req_d   = 1'b1;
                            we_d    = dec.is_store;
                            addr_d  = {bus.MEM_alures_in[ADDR_WIDTH-1:2], 2'b00};
                            be_d    = st_be;
                            wdata_d = dec.is_store ? st_wdata : '0;
                            pend_d  = dec;
                            off_d   = off;
                            rd_d    = bus.MEM_rd_in;
                        end else begin
                            trap_d  = 1'b1;
                        end
                    end else if (bus.MEM_op_in == OP_ARITH ||
                                 (bus.MEM_op_in == OP_BRANCH && bus.MEM_op2_in == OP2_SETHI)) begin
                        wb_en_d   = (bus.MEM_rd_in != 5'd0);
                        wb_rd_d   = bus.MEM_rd_in;
                        wb_data_d = bus.MEM_alures_in;
                    end else if (bus.MEM_op_in == OP_CALL) begin
                        wb_en_d   = 1'b1;
                        wb_rd_d   = RD_LINK;
                        wb_data_d = bus.MEM_alures_in;
                    end
                end
            end
            S_WAIT: begin
                if (bus.dmem_ack_in) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    be_d    = '0;
                    wdata_d = '0;
                    if (!pend_q.is_store) begin
                        wb_en_d   = (rd_q != 5'd0);
                        wb_rd_d   = rd_q;
                        wb_data_d = load_lane(pend_q, off_q, bus.dmem_rdata_in);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    // NOTE: non-blocking assignments here so every register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            trap_q    <= 1'b0;
            pend_q    <= MEMOP_NONE;
            off_q     <= '0;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            trap_q    <= trap_d;
            pend_q    <= pend_d;
            off_q     <= off_d;
            rd_q      <= rd_d;
        end
    end

    assign bus.mem_ready       = (state_q == S_IDLE);
    assign bus.dmem_req_out    = req_q;
    assign bus.dmem_we_out     = we_q;
    assign bus.dmem_addr_out   = addr_q;
    assign bus.dmem_be_out     = be_q;
    assign bus.dmem_wdata_out  = wdata_q;
    assign bus.MEM_wb_en_out   = wb_en_q;
    assign bus.MEM_wb_rd_out   = wb_rd_q;
    assign bus.MEM_wb_data_out = wb_data_q;
    assign bus.MEM_trap_out    = trap_q;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the five-stage SPARC V8 integer pipeline. Sits directly downstream of the Execute stage.
- Consumes the ALU result, destination register and opcode fields that Execute produces. Performs word, halfword and byte loads and stores over a single-outstanding data-memory handshake.
- Sends writeback data to the Writeback stage.
- Drives mem_ready back to Execute, so Execute holds its operands while an access is in flight.

Parameters:
- ADDR_WIDTH, 32, width of the data-memory byte address.
- DATA_WIDTH, 32, width of the data-memory data bus and the writeback value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MEM_valid_in  in  1  an Execute result is presented this cycle.
- MEM_alures_in  in  32  ALU result; the effective address for memory ops, the result value otherwise.
- MEM_store_data_in  in  32  rd register value to be stored.
- MEM_op_in  in  2  SPARC op field.
- MEM_op2_in  in  3  SPARC op2 field.
- MEM_op3_in  in  6  SPARC op3 field.
- MEM_rd_in  in  5  destination register.
- mem_ready  out  1  1 = stage can accept a new instruction; 0 = Execute must hold.
- dmem_req_out  out  1  memory request.
- dmem_we_out  out  1  1 = write request.
- dmem_addr_out  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- dmem_be_out  out  4  byte enables; bit 3 = bits [31:24] = byte offset 0 (big-endian).
- dmem_wdata_out  out  DATA_WIDTH  lane-replicated store data.
- dmem_ack_in  in  1  request completed; rdata valid on the same cycle for reads.
- dmem_rdata_in  in  DATA_WIDTH  read data word.
- MEM_wb_en_out  out  1  writeback valid.
- MEM_wb_rd_out  out  5  writeback register.
- MEM_wb_data_out  out  DATA_WIDTH  writeback value.
- MEM_trap_out  out  1  one-cycle pulse on a misaligned access.

Behaviour:
- Reset: state IDLE; mem_ready=1. All other outputs 0: req, we, addr, be, wdata, wb_en, wb_rd, wb_data, trap.
- Memory op decode: op==2'b11.
  - Loads: LD 000000, LDUB 000001, LDUH 000010, LDSB 001001, LDSH 001010.
  - Stores: ST 000100, STB 000101, STH 000110.
  - Any other op3 with op==11 is treated as a NOP: no access, no writeback.
- Alignment: word access needs addr[1:0]==0; halfword access needs addr[0]==0.
- IDLE with MEM_valid_in=1, non-memory op: registered pass-through, 1-cycle latency.
  - op==10: wb_en=1, wb_rd=rd, wb_data=alures.
  - op==00 with op2==100 (SETHI): same as op==10.
  - op==01 (CALL): wb_en=1, wb_rd=15, wb_data=alures.
  - Branches: wb_en=0.
- IDLE with MEM_valid_in=1, aligned memory op:
  - Next cycle: dmem_req_out=1, we per op, addr={alures[31:2],2'b00}, be/wdata per size. State goes to WAIT; mem_ready=0.
  - Byte store: wdata = byte replicated x4; be = 1000 >> addr[1:0].
  - Halfword store: wdata = halfword replicated x2; be = addr[1] ? 0011 : 1100.
  - Word store: be = 1111.
  - Load: be as for a store of the same size.
- IDLE with MEM_valid_in=1, misaligned memory op: no request. Next cycle MEM_trap_out=1 for one cycle and wb_en=0; state stays IDLE.
- WAIT:
  - req, we, addr, be and wdata are held stable until the cycle dmem_ack_in=1 is sampled.
  - Next cycle after ack: req=0, mem_ready=1, state IDLE.
  - For a load, also on that next cycle: wb_en=1, wb_rd=rd, wb_data = the selected lane.
  - LDUB/LDUH zero-extend; LDSB/LDSH sign-extend. Byte lane at offset 0 is rdata[31:24].
  - Stores: wb_en=0.
- Latency: load/store = 1 (request issue) + N wait cycles + 1, where N>=1 is the cycle count until ack is sampled. Zero-wait-state memory therefore gives 3 cycles from acceptance to writeback.
- mem_ready is combinational from state: 1 in IDLE, 0 in WAIT. MEM_valid_in is ignored while in WAIT; Execute holds its outputs.
- dmem_ack_in is ignored when not in WAIT.
- wb_en and trap are single-cycle pulses, 0 in all other cycles.
- rd==0: wb_en is forced to 0 (%g0 is never written). The access itself still occurs.
- Reset asserted mid-access (WAIT): return to the reset state next cycle. req drops, and a pending ack is ignored.

Test Plan:
- ADD result 0x0000_1234, rd=5, op=10 -> next cycle wb_en=1, wb_rd=5, wb_data=0x0000_1234; req never asserted; mem_ready stays 1.
- LD addr 0x100, rd=3, ack after 2 wait cycles with rdata 0xDEAD_BEEF -> req held with addr 0x100 and be 1111; mem_ready=0 during WAIT; wb_data=0xDEAD_BEEF the cycle after ack.
- LDSB addr 0x103, rdata 0x1122_33F0 -> be=0001; wb_data=0xFFFF_FFF0. LDUB at the same address -> wb_data=0x0000_00F0.
- STH addr 0x202, store data 0x0000_ABCD -> we=1, addr=0x200, be=0011, wdata=0xABCD_ABCD; wb_en stays 0.
- LD addr 0x101 -> no req; trap=1 for exactly one cycle; wb_en=0; mem_ready stays 1.
- Reset asserted during WAIT with ack arriving the same cycle -> next cycle req=0, mem_ready=1, wb_en=0.
